// File: rtl/datapath_sequencer.sv
// datapath_sequencer
//   Multi-cycle control FSM for the Mini SRC datapath. It steps each instruction
//   through fetch (T0-T2), decode and execute (T3-T7). On every cycle it drives the
//   datapath register strobes, the bus-source selects, gp_register_select and alu_op.
//   It also runs the memory handshake (mem_read / mem_write / mem_ready).
//   The block holds no datapath state: outputs are decoded from the state register
//   plus the IR fields. mem_ready is used only to finish a wait state (mdr_in and
//   state advance).
// Ports
//   clock, clear         : rising-edge clock, asynchronous active-low reset
//   run                  : start/continue fetching instructions
//   ir                   : IR contents {op[31:27], ra[26:23], rb[22:19], rc[18:15], ...}
//   mem_ready            : memory finishes the pending access this cycle
//   con_ff               : branch condition, sampled in T5 of br
//   pc_*, mar_in, mdr_*, ir_in, y_in, z_in, zlo_out, c_out, gp_out, gp_in : strobes
//   gp_register_select   : GP register index for gp_out / gp_in
//   alu_op               : 0 ADD, 1 SUB, 2 AND, 3 OR (0 whenever z_in is 0)
//   mem_read, mem_write  : memory requests, held until mem_ready
//   halted, fault        : sticky status; the only way out is clear
//   instr_count          : retired instructions, wraps
module datapath_sequencer #(
    parameter int WAIT_LIMIT = 16,
    parameter int CNT_W      = 16
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             run,
    input  logic [31:0]      ir,
    input  logic             mem_ready,
    input  logic             con_ff,
    output logic             pc_out,
    output logic             pc_in,
    output logic             pc_inc,
    output logic             mar_in,
    output logic             mdr_in,
    output logic             mdr_out,
    output logic             ir_in,
    output logic             y_in,
    output logic             z_in,
    output logic             zlo_out,
    output logic             c_out,
    output logic             gp_out,
    output logic             gp_in,
    output logic [3:0]       gp_register_select,
    output logic [3:0]       alu_op,
    output logic             mem_read,
    output logic             mem_write,
    output logic             halted,
    output logic             fault,
    output logic [CNT_W-1:0] instr_count
);

    localparam int WC_W = $clog2(WAIT_LIMIT + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT, S_FAULT
    } state_t;

    state_t          state, state_next;
    logic [WC_W-1:0] wait_cnt;
    logic            in_wait;
    logic            retire;

    // IR field decode
    logic [4:0] op;
    logic [3:0] ra, rb, rc;
    logic       is_alu, is_addi, is_ld, is_st, is_br, is_halt, is_mem;
    logic       unused_ir;

    assign op        = ir[31:27];
    assign ra        = ir[26:23];
    assign rb        = ir[22:19];
    assign rc        = ir[18:15];
    assign unused_ir = ^ir[14:0];    // immediate goes to the datapath, not the sequencer
    assign is_alu    = (op <= 5'h03);
    assign is_addi   = (op == 5'h04);
    assign is_ld     = (op == 5'h05);
    assign is_st     = (op == 5'h06);
    assign is_br     = (op == 5'h07);
    assign is_halt   = (op == 5'h1F);
    assign is_mem    = is_ld | is_st;

    always_comb begin
        state_next         = state;
        in_wait            = 1'b0;
        retire             = 1'b0;
        pc_out             = 1'b0;
        pc_in              = 1'b0;
        pc_inc             = 1'b0;
        mar_in             = 1'b0;
        mdr_in             = 1'b0;
        mdr_out            = 1'b0;
        ir_in              = 1'b0;
        y_in               = 1'b0;
        z_in               = 1'b0;
        zlo_out            = 1'b0;
        c_out              = 1'b0;
        gp_out             = 1'b0;
        gp_in              = 1'b0;
        gp_register_select = 4'd0;
        alu_op             = 4'd0;
        mem_read           = 1'b0;
        mem_write          = 1'b0;
        halted             = 1'b0;
        fault              = 1'b0;

        case (state)
            S_IDLE: if (run) state_next = S_T0;
            S_T0: begin
                pc_out     = 1'b1;
                mar_in     = 1'b1;
                pc_inc     = 1'b1;
                state_next = S_T1;
            end
            S_T1: begin
                in_wait  = 1'b1;
                mem_read = 1'b1;
                if (mem_ready) begin
                    mdr_in     = 1'b1;
                    state_next = S_T2;
                end
            end
            S_T2: begin
                mdr_out    = 1'b1;
                ir_in      = 1'b1;
                state_next = S_T3;
            end
            S_T3: begin
                if (is_alu || is_addi || is_mem) begin
                    gp_out             = 1'b1;
                    gp_register_select = rb;
                    y_in               = 1'b1;
                    state_next         = S_T4;
                end else if (is_br) begin
                    pc_out     = 1'b1;
                    y_in       = 1'b1;
                    state_next = S_T4;
                end else begin
                    retire = 1'b1;    // nop, unknown and halt all finish here
                end
            end
            S_T4: begin
                z_in = 1'b1;
                if (is_alu) begin
                    gp_out             = 1'b1;
                    gp_register_select = rc;
                    alu_op             = {2'b00, op[1:0]};
                end else begin
                    c_out = 1'b1;    // addi / ld / st / br all add C
                end
                state_next = S_T5;
            end
            S_T5: begin
                zlo_out = 1'b1;
                if (is_mem) begin
                    mar_in     = 1'b1;
                    state_next = S_T6;
                end else if (is_br) begin
                    pc_in  = con_ff;
                    retire = 1'b1;
                end else begin
                    gp_in              = 1'b1;
                    gp_register_select = ra;
                    retire             = 1'b1;
                end
            end
            S_T6: begin
                if (is_ld) begin
                    in_wait  = 1'b1;
                    mem_read = 1'b1;
                    if (mem_ready) begin
                        mdr_in     = 1'b1;
                        state_next = S_T7;
                    end
                end else begin
                    gp_out             = 1'b1;
                    gp_register_select = ra;
                    mdr_in             = 1'b1;
                    state_next         = S_T7;
                end
            end
            S_T7: begin
                if (is_ld) begin
                    mdr_out            = 1'b1;
                    gp_in              = 1'b1;
                    gp_register_select = ra;
                    retire             = 1'b1;
                end else begin
                    in_wait   = 1'b1;
                    mem_write = 1'b1;
                    retire    = mem_ready;
                end
            end
            S_HALT:  halted = 1'b1;
            S_FAULT: fault  = 1'b1;
            default: state_next = S_IDLE;
        endcase

        if (retire)
            state_next = is_halt ? S_HALT : (run ? S_T0 : S_IDLE);

        // The last permitted wait cycle without mem_ready is the one that faults.
        if (in_wait && !mem_ready && (wait_cnt == WC_W'(WAIT_LIMIT - 1)))
            state_next = S_FAULT;
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state       <= S_IDLE;
            wait_cnt    <= '0;
            instr_count <= '0;
        end else begin
            state <= state_next;
            // No two wait states are adjacent, so clearing outside them covers every entry.
            if (!in_wait)
                wait_cnt <= '0;
            else if (!mem_ready)
                wait_cnt <= wait_cnt + WC_W'(1);
            if (retire)
                instr_count <= instr_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_datapath_sequencer.sv
module tb_datapath_sequencer;

    localparam int CNT_W = 4;   // small so the random run also exercises wrap-around

    logic             clock, clear, run, mem_ready, con_ff;
    logic [31:0]      ir;
    logic             pc_out, pc_in, pc_inc, mar_in, mdr_in, mdr_out, ir_in, y_in, z_in;
    logic             zlo_out, c_out, gp_out, gp_in, mem_read, mem_write, halted, fault;
    logic [3:0]       gp_register_select, alu_op;
    logic [CNT_W-1:0] instr_count;

    datapath_sequencer #(.WAIT_LIMIT(16), .CNT_W(CNT_W)) dut (
        .clock(clock), .clear(clear), .run(run), .ir(ir), .mem_ready(mem_ready),
        .con_ff(con_ff), .pc_out(pc_out), .pc_in(pc_in), .pc_inc(pc_inc),
        .mar_in(mar_in), .mdr_in(mdr_in), .mdr_out(mdr_out), .ir_in(ir_in),
        .y_in(y_in), .z_in(z_in), .zlo_out(zlo_out), .c_out(c_out), .gp_out(gp_out),
        .gp_in(gp_in), .gp_register_select(gp_register_select), .alu_op(alu_op),
        .mem_read(mem_read), .mem_write(mem_write), .halted(halted), .fault(fault),
        .instr_count(instr_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // All outputs packed into one control word.
    logic [24:0] obs;
    assign obs = {pc_out, pc_in, pc_inc, mar_in, mdr_in, mdr_out, ir_in, y_in, z_in,
                  zlo_out, c_out, gp_out, gp_in, gp_register_select, alu_op,
                  mem_read, mem_write, halted, fault};

    localparam logic [24:0] PC_OUT = 25'(1) << 24, PC_IN  = 25'(1) << 23,
                            PC_INC = 25'(1) << 22, MAR_IN = 25'(1) << 21,
                            MDR_IN = 25'(1) << 20, MDR_OUT= 25'(1) << 19,
                            IR_IN  = 25'(1) << 18, Y_IN   = 25'(1) << 17,
                            Z_IN   = 25'(1) << 16, ZLO    = 25'(1) << 15,
                            C_OUT  = 25'(1) << 14, GP_OUT = 25'(1) << 13,
                            GP_IN  = 25'(1) << 12, MEM_RD = 25'(1) << 3,
                            MEM_WR = 25'(1) << 2,  HALTED = 25'(1) << 1,
                            FAULT  = 25'(1);
    localparam logic [24:0] T0W = PC_OUT | MAR_IN | PC_INC;

    function automatic logic [24:0] sl(input logic [3:0] r);
        return 25'(r) << 8;
    endfunction
    function automatic logic [24:0] al(input logic [3:0] a);
        return 25'(a) << 4;
    endfunction

    int n_chk = 0, n_pass = 0;

    // Reference model: per-cycle expected control words, built from the micro-op table.
    typedef struct {
        logic [31:0] ir;
        logic        con;
        logic        rdy;
        logic [24:0] w;
    } ent_t;
    ent_t q[$];

    task automatic put(input logic [31:0] i, input logic c, input logic r, input logic [24:0] w);
        ent_t e;
        e.ir = i; e.con = c; e.rdy = r; e.w = w;
        q.push_back(e);
    endtask

    // Cycles that are not memory waits get a random mem_ready, which must be ignored.
    task automatic put_x(input logic [31:0] i, input logic c, input logic [24:0] w);
        put(i, c, 1'($urandom_range(0, 1)), w);
    endtask

    task automatic build(input logic [31:0] i, input logic c, input int d1, input int d2);
        logic [4:0] op;
        logic [3:0] ra, rb, rc;
        op = i[31:27]; ra = i[26:23]; rb = i[22:19]; rc = i[18:15];
        put_x(i, c, T0W);
        for (int k = 0; k < d1; k++) put(i, c, 1'b0, MEM_RD);
        put(i, c, 1'b1, MEM_RD | MDR_IN);
        put_x(i, c, MDR_OUT | IR_IN);
        if (op <= 5'd7 && op != 5'd7) begin
            put_x(i, c, GP_OUT | Y_IN | sl(rb));
            if (op <= 5'd3) put_x(i, c, GP_OUT | Z_IN | sl(rc) | al({2'b00, op[1:0]}));
            else            put_x(i, c, C_OUT | Z_IN);
            if (op <= 5'd4) put_x(i, c, ZLO | GP_IN | sl(ra));
            else            put_x(i, c, ZLO | MAR_IN);
            if (op == 5'd5) begin
                for (int k = 0; k < d2; k++) put(i, c, 1'b0, MEM_RD);
                put(i, c, 1'b1, MEM_RD | MDR_IN);
                put_x(i, c, MDR_OUT | GP_IN | sl(ra));
            end else if (op == 5'd6) begin
                put_x(i, c, GP_OUT | MDR_IN | sl(ra));
                for (int k = 0; k < d2; k++) put(i, c, 1'b0, MEM_WR);
                put(i, c, 1'b1, MEM_WR);
            end
        end else if (op == 5'd7) begin
            put_x(i, c, PC_OUT | Y_IN);
            put_x(i, c, C_OUT | Z_IN);
            put_x(i, c, ZLO | (c ? PC_IN : 25'd0));
        end else begin
            put_x(i, c, 25'd0);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Leaves the DUT in IDLE at 1 time unit after a rising edge.
    task automatic do_reset();
        run = 1'b0; mem_ready = 1'b0; con_ff = 1'b0; ir = 32'd0;
        clear = 1'b1;
        #1 clear = 1'b0;
        repeat (2) @(posedge clock);
        #1 clear = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #2;
        n_chk++;
        if (obs !== 25'd0) $display("FAIL reset_outputs got %h want %h", obs, 25'd0);
        else n_pass++;
        n_chk++;
        if (instr_count !== '0) $display("FAIL reset_count got %0d want 0", instr_count);
        else n_pass++;
    endtask

    task automatic test_add();
        do_reset();
        ir = 32'h01890000; run = 1'b1; mem_ready = 1'b1;
        tick(); #3;
        n_chk++;
        if (obs !== T0W) $display("FAIL add_T0 got %h want %h", obs, T0W); else n_pass++;
        tick(); #3;
        n_chk++;
        if (obs !== (MEM_RD | MDR_IN)) $display("FAIL add_T1 got %h want %h", obs, MEM_RD | MDR_IN);
        else n_pass++;
        tick(); tick(); #3;
        n_chk++;
        if (obs !== (GP_OUT | Y_IN | sl(4'd1))) $display("FAIL add_T3 got %h want %h", obs, GP_OUT | Y_IN | sl(4'd1));
        else n_pass++;
        tick(); #3;
        n_chk++;
        if (obs !== (GP_OUT | Z_IN | sl(4'd2))) $display("FAIL add_T4 got %h want %h", obs, GP_OUT | Z_IN | sl(4'd2));
        else n_pass++;
        tick(); #3;
        n_chk++;
        if (obs !== (ZLO | GP_IN | sl(4'd3)) || instr_count !== 4'd0)
            $display("FAIL add_T5 got %h cnt %0d want %h cnt 0", obs, instr_count, ZLO | GP_IN | sl(4'd3));
        else n_pass++;
        tick(); #3;
        n_chk++;
        if (obs !== T0W || instr_count !== 4'd1)
            $display("FAIL add_retire got %h cnt %0d want %h cnt 1", obs, instr_count, T0W);
        else n_pass++;
    endtask

    task automatic test_ld_wait();
        int rd, md;
        do_reset();
        ir = 32'h28880004; run = 1'b1; mem_ready = 1'b1;
        repeat (7) tick();    // IDLE -> T6
        rd = 0; md = 0;
        for (int k = 0; k < 5; k++) begin
            mem_ready = (k == 3);
            if (k == 4) run = 1'b0;
            #3;
            rd += int'(mem_read);
            md += int'(mdr_in);
            if (k == 4) begin
                n_chk++;
                if (obs !== (MDR_OUT | GP_IN | sl(4'd1)))
                    $display("FAIL ld_T7 got %h want %h", obs, MDR_OUT | GP_IN | sl(4'd1));
                else n_pass++;
            end
            tick();
        end
        n_chk++;
        if (rd != 4) $display("FAIL ld_mem_read_cycles got %0d want 4", rd); else n_pass++;
        n_chk++;
        if (md != 1) $display("FAIL ld_mdr_in_cycles got %0d want 1", md); else n_pass++;
        n_chk++;
        if (instr_count !== 4'd1) $display("FAIL ld_count got %0d want 1", instr_count); else n_pass++;
    endtask

    task automatic test_branch();
        int p0, p1;
        do_reset();
        ir = 32'h38000005; run = 1'b1; mem_ready = 1'b1; con_ff = 1'b0;
        tick();
        p0 = 0; p1 = 0;
        for (int c = 0; c < 6; c++) begin
            #3;
            p0 += int'(pc_in);
            if (c == 5) begin
                n_chk++;
                if (obs !== ZLO) $display("FAIL br_nt_T5 got %h want %h", obs, ZLO); else n_pass++;
            end
            tick();
        end
        con_ff = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #3;
            p1 += int'(pc_in);
            if (c == 5) begin
                n_chk++;
                if (obs !== (ZLO | PC_IN)) $display("FAIL br_t_T5 got %h want %h", obs, ZLO | PC_IN); else n_pass++;
            end
            tick();
        end
        n_chk++;
        if (p0 != 0 || p1 != 1) $display("FAIL br_pc_in_cycles got %0d/%0d want 0/1", p0, p1); else n_pass++;
        n_chk++;
        if (instr_count !== 4'd2) $display("FAIL br_count got %0d want 2", instr_count); else n_pass++;
    endtask

    task automatic test_fault();
        int n, bad;
        do_reset();
        ir = 32'd0; run = 1'b1; mem_ready = 1'b0;
        tick(); tick();    // T1
        n = 0;
        while (mem_read && n < 40) begin
            n++;
            tick();
        end
        n_chk++;
        if (n != 16) $display("FAIL fault_wait_cycles got %0d want 16", n); else n_pass++;
        n_chk++;
        if (obs !== FAULT) $display("FAIL fault_state got %h want %h", obs, FAULT); else n_pass++;
        bad = 0;
        mem_ready = 1'b1;
        repeat (5) begin
            tick();
            if (obs !== FAULT) bad++;
        end
        n_chk++;
        if (bad != 0) $display("FAIL fault_sticky got %0d bad cycles want 0", bad); else n_pass++;
    endtask

    task automatic test_clear_mid();
        do_reset();
        ir = 32'h28880004; run = 1'b1; mem_ready = 1'b1;
        repeat (7) tick();
        mem_ready = 1'b0;
        #2;
        n_chk++;
        if (mem_read !== 1'b1) $display("FAIL clr_pre_read got %b want 1", mem_read); else n_pass++;
        clear = 1'b0;
        #1;
        n_chk++;
        if (obs !== 25'd0) $display("FAIL clr_async got %h want %h", obs, 25'd0); else n_pass++;
        tick();
        clear = 1'b1; run = 1'b0;
        #3;
        n_chk++;
        if (obs !== 25'd0) $display("FAIL clr_idle got %h want %h", obs, 25'd0); else n_pass++;
        run = 1'b1;
        tick(); #3;
        n_chk++;
        if (obs !== T0W) $display("FAIL clr_restart got %h want %h", obs, T0W); else n_pass++;
    endtask

    task automatic test_halt();
        int bad;
        do_reset();
        ir = 32'hF8000000; run = 1'b1; mem_ready = 1'b1;
        repeat (4) tick();    // T3
        #3;
        n_chk++;
        if (obs !== 25'd0 || instr_count !== 4'd0)
            $display("FAIL halt_T3 got %h cnt %0d want 0 cnt 0", obs, instr_count);
        else n_pass++;
        bad = 0;
        repeat (20) begin
            tick();
            if (obs !== HALTED) bad++;
        end
        n_chk++;
        if (bad != 0) $display("FAIL halt_sticky got %0d bad cycles want 0", bad); else n_pass++;
        n_chk++;
        if (instr_count !== 4'd1) $display("FAIL halt_count got %0d want 1", instr_count); else n_pass++;
    endtask

    task automatic test_back_to_back();
        ent_t e;
        int   n_ins;
        logic [4:0] op;
        n_ins = 40;
        q.delete();
        for (int k = 0; k < n_ins; k++) begin
            int r;
            r  = int'($urandom_range(0, 12));
            op = (r <= 8) ? 5'(r) : 5'($urandom_range(9, 30));
            build({op, 27'($urandom)}, 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 5)), int'($urandom_range(0, 5)));
        end
        do_reset();
        run = 1'b1;
        ir = q[0].ir;
        tick();    // IDLE -> T0
        while (q.size() > 0) begin
            e = q.pop_front();
            ir = e.ir; con_ff = e.con; mem_ready = e.rdy;
            #3;
            n_chk++;
            if (obs !== e.w) $display("FAIL rand_cycle ir %h got %h want %h", e.ir, obs, e.w);
            else n_pass++;
            tick();
        end
        n_chk++;
        if (instr_count !== CNT_W'(n_ins))
            $display("FAIL rand_count got %0d want %0d", instr_count, CNT_W'(n_ins));
        else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_add();
        test_ld_wait();
        test_branch();
        test_fault();
        test_clear_mid();
        test_halt();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
